// File: rtl/intersection_ctrl.sv
// rtl/intersection_ctrl.sv - four-way intersection signal controller with preemption and flash
//
// Sequences NS/EW protected-left, green, yellow and all-red clearance phases.
// An emergency request forces solid all-red and freezes all timing state.
// Normal timing resumes from that frozen state when the request drops.
// A flash request blinks NS yellow and EW red.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active-high
//   emergency    emergency vehicle present (level)
//   flash        night flash request (level)
//   ns_out       NS head {left, green, yellow, red}
//   ew_out       EW head {left, green, yellow, red}
//   phase        current normal phase code (7 while flashing)
//   emerg_active all-red preemption in force
//   flash_active flash mode in force
module intersection_ctrl #(
  parameter int LEFT_CYC   = 5,
  parameter int GREEN_CYC  = 10,
  parameter int YELLOW_CYC = 3,
  parameter int ALLRED_CYC = 1,
  parameter int FLASH_CYC  = 4,
  parameter int CNT_W      = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       emergency,
  input  logic       flash,
  output logic [3:0] ns_out,
  output logic [3:0] ew_out,
  output logic [2:0] phase,
  output logic       emerg_active,
  output logic       flash_active
);

  localparam logic [2:0] PH_NS_LEFT   = 3'd0;
  localparam logic [2:0] PH_NS_GREEN  = 3'd1;
  localparam logic [2:0] PH_NS_YELLOW = 3'd2;
  localparam logic [2:0] PH_ALLRED_A  = 3'd3;
  localparam logic [2:0] PH_EW_LEFT   = 3'd4;
  localparam logic [2:0] PH_EW_GREEN  = 3'd5;
  localparam logic [2:0] PH_EW_YELLOW = 3'd6;
  localparam logic [2:0] PH_ALLRED_B  = 3'd7;

  localparam logic [3:0] H_LEFT   = 4'b1001;
  localparam logic [3:0] H_GREEN  = 4'b0100;
  localparam logic [3:0] H_YELLOW = 4'b0010;
  localparam logic [3:0] H_RED    = 4'b0001;
  localparam logic [3:0] H_DARK   = 4'b0000;

  localparam logic [CNT_W-1:0] LEFT_LAST   = CNT_W'(LEFT_CYC - 1);
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_CYC - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST  = CNT_W'(FLASH_CYC - 1);

  logic [2:0]       phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             emerg_q, emerg_d;
  logic             flash_q, flash_d;
  logic             blink_q, blink_d;
  logic [CNT_W-1:0] phase_last;

  // Last count value of the current phase; both directions share durations.
  always_comb begin
    phase_last = ALLRED_LAST;
    case (phase_q[1:0])
      2'd0:    phase_last = LEFT_LAST;
      2'd1:    phase_last = GREEN_LAST;
      2'd2:    phase_last = YELLOW_LAST;
      default: phase_last = ALLRED_LAST;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_NS_LEFT;
      cnt_q   <= '0;
      emerg_q <= 1'b0;
      flash_q <= 1'b0;
      blink_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      emerg_q <= emerg_d;
      flash_q <= flash_d;
      blink_q <= blink_d;
    end
  end

  // Next-state logic
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    emerg_d = emerg_q;
    flash_d = flash_q;
    blink_d = blink_q;
    if (emergency) begin
      // Everything else is frozen so the interrupted phase resumes intact.
      emerg_d = 1'b1;
    end else begin
      emerg_d = 1'b0;
      if (flash && !flash_q) begin
        flash_d = 1'b1;
        cnt_d   = '0;
        blink_d = 1'b1;
        phase_d = PH_ALLRED_B;
      end else if (!flash && flash_q) begin
        // Leaving flash always goes through all-red clearance first.
        flash_d = 1'b0;
        phase_d = PH_ALLRED_B;
        cnt_d   = '0;
      end else if (!emerg_q) begin
        // The release edge after an emergency does not count.
        if (flash_q) begin
          if (cnt_q == FLASH_LAST) begin
            cnt_d   = '0;
            blink_d = ~blink_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (cnt_q == phase_last) begin
          cnt_d   = '0;
          phase_d = phase_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  // Output decode, from registered state only
  always_comb begin
    ns_out       = H_RED;
    ew_out       = H_RED;
    phase        = phase_q;
    emerg_active = emerg_q;
    flash_active = flash_q;
    if (emerg_q) begin
      ns_out = H_RED;
      ew_out = H_RED;
    end else if (flash_q) begin
      ns_out = blink_q ? H_YELLOW : H_DARK;
      ew_out = blink_q ? H_RED : H_DARK;
    end else begin
      case (phase_q)
        PH_NS_LEFT:   ns_out = H_LEFT;
        PH_NS_GREEN:  ns_out = H_GREEN;
        PH_NS_YELLOW: ns_out = H_YELLOW;
        PH_EW_LEFT:   ew_out = H_LEFT;
        PH_EW_GREEN:  ew_out = H_GREEN;
        PH_EW_YELLOW: ew_out = H_YELLOW;
        default: begin
          ns_out = H_RED;
          ew_out = H_RED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intersection_ctrl.sv
// tb/tb_intersection_ctrl.sv - self-checking bench for intersection_ctrl
module tb_intersection_ctrl;

  localparam int FLASH_CYC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic emergency = 1'b0;
  logic flash = 1'b0;

  logic [3:0] ns_a, ew_a, ns_b, ew_b;
  logic [2:0] ph_a, ph_b;
  logic       em_a, em_b, fl_a, fl_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  intersection_ctrl dut_a (
    .clk(clk), .rst(rst), .emergency(emergency), .flash(flash),
    .ns_out(ns_a), .ew_out(ew_a), .phase(ph_a),
    .emerg_active(em_a), .flash_active(fl_a)
  );

  intersection_ctrl #(.LEFT_CYC(1), .GREEN_CYC(20), .CNT_W(5)) dut_b (
    .clk(clk), .rst(rst), .emergency(emergency), .flash(flash),
    .ns_out(ns_b), .ew_out(ew_b), .phase(ph_b),
    .emerg_active(em_b), .flash_active(fl_b)
  );

  // Model: remaining-time countdown per instance
  logic [3:0] ns_tab [8] = '{4'b1001, 4'b0100, 4'b0010, 4'b0001,
                             4'b0001, 4'b0001, 4'b0001, 4'b0001};
  logic [3:0] ew_tab [8] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                             4'b1001, 4'b0100, 4'b0010, 4'b0001};
  int  m_ph [2];
  int  m_left [2];
  int  m_fleft [2];
  bit  m_em [2];
  bit  m_fl [2];
  bit  m_bl [2];
  bit  m_valid = 1'b0;

  function automatic int dur_of(input int i, input int p);
    case (p % 4)
      0:       return (i == 0) ? 5 : 1;
      1:       return (i == 0) ? 10 : 20;
      2:       return 3;
      default: return 1;
    endcase
  endfunction

  task automatic model_step(input int i);
    bit was_em;
    if (rst) begin
      m_ph[i] = 0; m_left[i] = dur_of(i, 0); m_em[i] = 0;
      m_fl[i] = 0; m_bl[i] = 0; m_fleft[i] = FLASH_CYC;
      m_valid = 1'b1;
    end else if (emergency) begin
      m_em[i] = 1;
    end else begin
      was_em = m_em[i];
      m_em[i] = 0;
      if (flash && !m_fl[i]) begin
        m_fl[i] = 1; m_bl[i] = 1; m_fleft[i] = FLASH_CYC;
      end else if (!flash && m_fl[i]) begin
        m_fl[i] = 0; m_ph[i] = 7; m_left[i] = dur_of(i, 7);
      end else if (!was_em) begin
        if (m_fl[i]) begin
          m_fleft[i]--;
          if (m_fleft[i] == 0) begin
            m_bl[i] = !m_bl[i];
            m_fleft[i] = FLASH_CYC;
          end
        end else begin
          m_left[i]--;
          if (m_left[i] == 0) begin
            m_ph[i] = (m_ph[i] + 1) % 8;
            m_left[i] = dur_of(i, m_ph[i]);
          end
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step(0);
    model_step(1);
  end

  // Compare process: every cycle once a reset has been seen
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      for (int i = 0; i < 2; i++) begin
        logic [3:0] a_ns, a_ew, e_ns, e_ew;
        logic [2:0] a_ph;
        logic       a_em, a_fl;
        int         e_ph;
        a_ns = (i == 0) ? ns_a : ns_b;
        a_ew = (i == 0) ? ew_a : ew_b;
        a_ph = (i == 0) ? ph_a : ph_b;
        a_em = (i == 0) ? em_a : em_b;
        a_fl = (i == 0) ? fl_a : fl_b;
        if (m_em[i]) begin
          e_ns = 4'b0001; e_ew = 4'b0001;
        end else if (m_fl[i]) begin
          e_ns = m_bl[i] ? 4'b0010 : 4'b0000;
          e_ew = m_bl[i] ? 4'b0001 : 4'b0000;
        end else begin
          e_ns = ns_tab[m_ph[i]]; e_ew = ew_tab[m_ph[i]];
        end
        e_ph = m_fl[i] ? 7 : m_ph[i];
        chk($sformatf("model_ns[%0d]", i), 32'(a_ns), 32'(e_ns));
        chk($sformatf("model_ew[%0d]", i), 32'(a_ew), 32'(e_ew));
        chk($sformatf("model_phase[%0d]", i), 32'(a_ph), 32'(e_ph));
        chk($sformatf("model_emerg[%0d]", i), 32'(a_em), 32'(m_em[i]));
        chk($sformatf("model_flash[%0d]", i), 32'(a_fl), 32'(m_fl[i]));
        chk($sformatf("dual_non_red[%0d]", i),
            32'((a_ns[3:1] != 3'b000) && (a_ew[3:1] != 3'b000)), 32'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  // Leaves the bench at the negedge where the reset state is visible (cycle 0).
  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic adv(input int n);
    repeat (n) step();
  endtask

  initial begin
    int p;
    logic [3:0] e_ns, e_ew;
    step();
    chk("reset_ns", 32'(ns_a), 32'h9);
    chk("reset_ew", 32'(ew_a), 32'h1);
    chk("reset_phase", 32'(ph_a), 32'd0);
    rst = 1'b0;

    // Two free-running periods with hand-counted run lengths
    for (int c = 0; c < 76; c++) begin
      p = c % 38;
      e_ns = (p < 5) ? 4'b1001 : (p < 15) ? 4'b0100 : (p < 18) ? 4'b0010 : 4'b0001;
      e_ew = (p < 19) ? 4'b0001 : (p < 24) ? 4'b1001 : (p < 34) ? 4'b0100 :
             (p < 37) ? 4'b0010 : 4'b0001;
      chk($sformatf("free_ns c=%0d", c), 32'(ns_a), 32'(e_ns));
      chk($sformatf("free_ew c=%0d", c), 32'(ew_a), 32'(e_ew));
      if (c < 22) begin
        e_ns = (c == 0) ? 4'b1001 : (c < 21) ? 4'b0100 : 4'b0010;
        chk($sformatf("param_ns c=%0d", c), 32'(ns_b), 32'(e_ns));
      end
      step();
    end

    // Emergency for 4 cycles when NS_GREEN cnt=3
    do_reset();
    adv(8);
    emergency = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("emerg_ns", 32'(ns_a), 32'h1);
      chk("emerg_ew", 32'(ew_a), 32'h1);
      chk("emerg_active", 32'(em_a), 32'd1);
      chk("emerg_phase_frozen", 32'(ph_a), 32'd1);
    end
    emergency = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step();
      chk("resume_green", 32'(ns_a), 32'h4);
    end
    step();
    chk("resume_yellow", 32'(ns_a), 32'h2);

    // One-cycle pulse during ALLRED_A
    do_reset();
    adv(18);
    emergency = 1'b1;
    step();
    chk("pulse_a_em", 32'(em_a), 32'd1);
    emergency = 1'b0;
    step();
    chk("pulse_a_phase", 32'(ph_a), 32'd3);
    chk("pulse_a_em_off", 32'(em_a), 32'd0);
    step();
    chk("pulse_a_next", 32'(ew_a), 32'h9);

    // One-cycle pulse on last NS_YELLOW cycle
    do_reset();
    adv(17);
    emergency = 1'b1;
    step();
    chk("pulse_y_ns", 32'(ns_a), 32'h1);
    emergency = 1'b0;
    step();
    chk("pulse_y_ns_back", 32'(ns_a), 32'h2);
    step();
    chk("pulse_y_next", 32'(ph_a), 32'd3);

    // Flash held for 20 cycles from EW_GREEN
    do_reset();
    adv(24);
    flash = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      chk($sformatf("flash_ns k=%0d", k), 32'(ns_a), ((k / 4) % 2 == 0) ? 32'h2 : 32'h0);
      chk($sformatf("flash_ew k=%0d", k), 32'(ew_a), ((k / 4) % 2 == 0) ? 32'h1 : 32'h0);
      chk("flash_phase", 32'(ph_a), 32'd7);
    end
    flash = 1'b0;
    step();
    chk("flash_exit_phase", 32'(ph_a), 32'd7);
    chk("flash_exit_ns", 32'(ns_a), 32'h1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("flash_exit_left", 32'(ns_a), 32'h9);
    end
    step();
    chk("flash_exit_green", 32'(ns_a), 32'h4);

    // Emergency during flash, blink resumes from frozen state
    do_reset();
    flash = 1'b1;
    adv(6);
    chk("ef_pre", 32'(ns_a), 32'h0);
    emergency = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("ef_red_ns", 32'(ns_a), 32'h1);
      chk("ef_red_ew", 32'(ew_a), 32'h1);
    end
    emergency = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("ef_resume_dark", 32'(ns_a), 32'h0);
    end
    step();
    chk("ef_resume_lit", 32'(ns_a), 32'h2);

    // Reset mid-emergency, held two cycles with inputs high
    emergency = 1'b1;
    step();
    chk("rst_pre_em", 32'(em_a), 32'd1);
    rst = 1'b1;
    adv(2);
    chk("rst_em_ns", 32'(ns_a), 32'h9);
    chk("rst_em_active", 32'(em_a), 32'd0);
    chk("rst_fl_active", 32'(fl_a), 32'd0);
    rst = 1'b0;
    emergency = 1'b0;
    flash = 1'b0;
    step();
    chk("rst_after_b_green", 32'(ns_b), 32'h4);
    adv(20);
    chk("rst_after_b_yellow", 32'(ns_b), 32'h2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
